// File: rtl/ghr_ckpt_pkg.sv
// ghr_ckpt_pkg -- shared defaults and width helpers for the global-history
// register with checkpoint ring (ghr_ckpt).
//
// Contents:
//   DEFAULT_HIST_W      default GHR width
//   DEFAULT_CKPT_DEPTH  default number of checkpoint slots
//   DEFAULT_FOLD_W      default folded-history width (used with GHR_FOLD_EN)
//   ptr_w(depth)        width of a slot pointer / checkpoint tag
//   cnt_w(depth)        width of the live-slot counter (must hold 0..depth)
package ghr_ckpt_pkg;

    localparam int DEFAULT_HIST_W     = 14;
    localparam int DEFAULT_CKPT_DEPTH = 8;
    localparam int DEFAULT_FOLD_W     = 10;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit so a completely full ring (cnt == depth) is representable.
    function automatic int cnt_w(input int depth);
        return ptr_w(depth) + 1;
    endfunction

endpackage

// File: rtl/ghr_ckpt_ram.sv
// ghr_ckpt_ram -- DEPTH x WIDTH register array holding GHR checkpoints.
//
// Ports:
//   i_clk     clock, rising edge
//   i_we      write enable (one checkpoint saved this cycle)
//   i_waddr   write slot (ring tail)
//   i_wdata   pre-shift GHR value to save
//   i_raddr   read slot (recovery tag), asynchronous read
//   o_rdata   saved GHR at i_raddr
//
// No reset: slot contents are only meaningful while the slot is live, and a
// slot always gets written before it becomes live.
module ghr_ckpt_ram
    import ghr_ckpt_pkg::*;
#(
    parameter int DEPTH = DEFAULT_CKPT_DEPTH,
    parameter int WIDTH = DEFAULT_HIST_W,
    parameter int AW    = ptr_w(DEFAULT_CKPT_DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ghr_ckpt.sv
// ghr_ckpt -- global-history register for the branch predictor with a
// checkpoint ring used for misprediction recovery.
//
// Each accepted speculative branch saves the pre-shift GHR into the slot at
// the ring tail (tag returned on o_ckpt_id) and shifts its predicted
// direction in. A recovery restores the tagged slot, shifts in the actual
// direction and squashes every younger slot. Retire frees the oldest slot.
//
// Build option: define GHR_FOLD_EN to add the FOLD_W parameter and the
// o_fold_hist port (XOR-fold of the GHR in FOLD_W-bit chunks, registered).
//
// Ports:
//   i_clk            clock, rising edge
//   i_reset          synchronous, active-low reset
//   i_spec_en        speculative shift request
//   i_spec_taken     predicted direction
//   o_ckpt_id        tag allocated to a spec request (== ring tail)
//   o_ckpt_full      all slots live; spec requests refused
//   o_ckpt_empty     no live slots
//   o_ckpt_cnt       number of live slots
//   i_retire_en      free the oldest slot
//   i_recover_en     misprediction recovery request
//   i_recover_id     tag of the mispredicted branch
//   i_recover_taken  actual direction
//   o_recover_err    1-cycle pulse: recovery tag was not live, ignored
//   o_fold_hist      folded GHR (GHR_FOLD_EN only)
//   o_hist           current GHR
//
// Handshake: requests are single-cycle strobes with no ready; a spec request
// is taken only when o_ckpt_full is low and no recovery is requested in the
// same cycle, so upstream must hold off while o_ckpt_full is high.
module ghr_ckpt
    import ghr_ckpt_pkg::*;
#(
`ifdef GHR_FOLD_EN
    parameter int FOLD_W     = DEFAULT_FOLD_W,
`endif
    parameter int HIST_W     = DEFAULT_HIST_W,
    parameter int CKPT_DEPTH = DEFAULT_CKPT_DEPTH
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_spec_en,
    input  logic                          i_spec_taken,
    output logic [ptr_w(CKPT_DEPTH)-1:0]  o_ckpt_id,
    output logic                          o_ckpt_full,
    output logic                          o_ckpt_empty,
    output logic [cnt_w(CKPT_DEPTH)-1:0]  o_ckpt_cnt,
    input  logic                          i_retire_en,
    input  logic                          i_recover_en,
    input  logic [ptr_w(CKPT_DEPTH)-1:0]  i_recover_id,
    input  logic                          i_recover_taken,
    output logic                          o_recover_err,
`ifdef GHR_FOLD_EN
    output logic [FOLD_W-1:0]             o_fold_hist,
`endif
    output logic [HIST_W-1:0]             o_hist
);

    localparam int PTR_W = ptr_w(CKPT_DEPTH);
    localparam int CNT_W = cnt_w(CKPT_DEPTH);

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_cnt;
    logic [HIST_W-1:0] r_hist;
    logic              r_recover_err;

    logic              w_full;
    logic              w_empty;
    logic [PTR_W-1:0]  w_off;
    logic              w_live;
    logic              w_rec_ok;
    logic              w_rec_bad;
    logic              w_spec_ok;
    logic              w_ret_ok;
    logic [HIST_W-1:0] w_slot;
    logic [HIST_W-1:0] w_hist_nxt;
    logic [PTR_W-1:0]  w_tail_nxt;
    logic [PTR_W-1:0]  w_head_nxt;
    logic [CNT_W-1:0]  w_cnt_base;
    logic [CNT_W-1:0]  w_cnt_nxt;

    assign w_full  = (r_cnt == CNT_W'(CKPT_DEPTH));
    assign w_empty = (r_cnt == '0);

    // Age of the recovery tag relative to the oldest live slot; the modulo
    // comes for free from the PTR_W-bit subtraction (depth is a power of 2).
    assign w_off  = i_recover_id - r_head;
    assign w_live = (CNT_W'(w_off) < r_cnt);

    assign w_rec_ok  = i_recover_en && w_live;
    assign w_rec_bad = i_recover_en && !w_live;
    assign w_spec_ok = i_spec_en && !w_full && !i_recover_en;
    assign w_ret_ok  = i_retire_en && !w_empty;

    ghr_ckpt_ram #(
        .DEPTH (CKPT_DEPTH),
        .WIDTH (HIST_W),
        .AW    (PTR_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_spec_ok && i_reset),
        .i_waddr (r_tail),
        .i_wdata (r_hist),
        .i_raddr (i_recover_id),
        .o_rdata (w_slot)
    );

    always_comb begin
        w_hist_nxt = r_hist;
        w_tail_nxt = r_tail;
        w_cnt_base = r_cnt;
        if (w_rec_ok) begin
            w_hist_nxt = {w_slot[HIST_W-2:0], i_recover_taken};
            w_tail_nxt = i_recover_id + PTR_W'(1);
            // Recovered slot stays live: everything up to and including it.
            w_cnt_base = CNT_W'(w_off) + CNT_W'(1);
        end else if (w_spec_ok) begin
            w_hist_nxt = {r_hist[HIST_W-2:0], i_spec_taken};
            w_tail_nxt = r_tail + PTR_W'(1);
            w_cnt_base = r_cnt + CNT_W'(1);
        end
        // A concurrent retire removes the oldest slot on top of the above;
        // it was judged against the registered count, so this cannot underflow.
        w_cnt_nxt = w_ret_ok ? (w_cnt_base - CNT_W'(1)) : w_cnt_base;
    end

    assign w_head_nxt = w_ret_ok ? (r_head + PTR_W'(1)) : r_head;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_cnt         <= '0;
            r_hist        <= '0;
            r_recover_err <= 1'b0;
        end else begin
            r_head        <= w_head_nxt;
            r_tail        <= w_tail_nxt;
            r_cnt         <= w_cnt_nxt;
            r_hist        <= w_hist_nxt;
            r_recover_err <= w_rec_bad;
        end
    end

`ifdef GHR_FOLD_EN
    localparam int NCHUNK = (HIST_W + FOLD_W - 1) / FOLD_W;

    logic [NCHUNK*FOLD_W-1:0] w_pad;
    logic [FOLD_W-1:0]        w_fold_nxt;
    logic [FOLD_W-1:0]        r_fold;

    // Fold the next-state history so the registered result lines up with
    // r_hist in the same cycle. The zero-extension pads the last chunk.
    assign w_pad = (NCHUNK*FOLD_W)'(w_hist_nxt);

    always_comb begin
        w_fold_nxt = '0;
        for (int c = 0; c < NCHUNK; c++) begin
            w_fold_nxt = w_fold_nxt ^ w_pad[c*FOLD_W +: FOLD_W];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_fold <= '0;
        end else begin
            r_fold <= w_fold_nxt;
        end
    end

    assign o_fold_hist = r_fold;
`endif

    assign o_ckpt_id     = r_tail;
    assign o_ckpt_full   = w_full;
    assign o_ckpt_empty  = w_empty;
    assign o_ckpt_cnt    = r_cnt;
    assign o_recover_err = r_recover_err;
    assign o_hist        = r_hist;

endmodule

// File: tb/tb_ghr_ckpt.sv
// tb_ghr_ckpt -- self-checking bench for ghr_ckpt (default parameters).
// Reference model: a queue of live checkpoints {tag, saved history}; liveness
// is membership in the queue, recovery truncates the queue after the tag.
module tb_ghr_ckpt;

    localparam int HW = 14;
    localparam int D  = 8;
    localparam int FW = 10;
    localparam int PW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_spec_en = 1'b0;
    logic          i_spec_taken = 1'b0;
    logic [PW-1:0] o_ckpt_id;
    logic          o_ckpt_full;
    logic          o_ckpt_empty;
    logic [CW-1:0] o_ckpt_cnt;
    logic          i_retire_en = 1'b0;
    logic          i_recover_en = 1'b0;
    logic [PW-1:0] i_recover_id = '0;
    logic          i_recover_taken = 1'b0;
    logic          o_recover_err;
    logic [HW-1:0] o_hist;
`ifdef GHR_FOLD_EN
    logic [FW-1:0] o_fold_hist;
`endif

    always #5 clk = ~clk;

    ghr_ckpt dut (
        .i_clk           (clk),
        .i_reset         (i_reset),
        .i_spec_en       (i_spec_en),
        .i_spec_taken    (i_spec_taken),
        .o_ckpt_id       (o_ckpt_id),
        .o_ckpt_full     (o_ckpt_full),
        .o_ckpt_empty    (o_ckpt_empty),
        .o_ckpt_cnt      (o_ckpt_cnt),
        .i_retire_en     (i_retire_en),
        .i_recover_en    (i_recover_en),
        .i_recover_id    (i_recover_id),
        .i_recover_taken (i_recover_taken),
        .o_recover_err   (o_recover_err),
`ifdef GHR_FOLD_EN
        .o_fold_hist     (o_fold_hist),
`endif
        .o_hist          (o_hist)
    );

    typedef struct {
        int            id;
        logic [HW-1:0] h;
    } ent_t;

    ent_t          live_q[$];
    int            m_tail;
    logic [HW-1:0] m_hist;
    bit            m_err;
    int            vectors = 0;
    int            miscompares = 0;

    function automatic logic [FW-1:0] fold_of(input logic [HW-1:0] h);
        logic [FW-1:0] f = '0;
        for (int i = 0; i < HW; i++) f[i % FW] ^= h[i];
        return f;
    endfunction

    task automatic model_step(input bit rst_n, input bit se, input bit st, input bit re,
                              input bit rce, input int rid, input bit rct);
        int  k;
        int  pre_size;
        bit  err;
        bit  ret;
        ent_t e;
        if (!rst_n) begin
            live_q.delete();
            m_tail = 0;
            m_hist = '0;
            m_err  = 1'b0;
            return;
        end
        pre_size = live_q.size();
        ret = re && (pre_size != 0);
        err = 1'b0;
        if (rce) begin
            k = -1;
            foreach (live_q[i]) if (live_q[i].id == rid) k = i;
            if (k >= 0) begin
                m_hist = {live_q[k].h[HW-2:0], rct};
                while (live_q.size() > k + 1) void'(live_q.pop_back());
                m_tail = (rid + 1) % D;
            end else begin
                err = 1'b1;
            end
        end else if (se && pre_size < D) begin
            e.id = m_tail;
            e.h  = m_hist;
            live_q.push_back(e);
            m_hist = {m_hist[HW-2:0], st};
            m_tail = (m_tail + 1) % D;
        end
        if (ret) void'(live_q.pop_front());
        m_err = err;
    endtask

    // Drive one cycle of requests from a negedge, advance the model, and
    // return at the next negedge with inputs idle.
    task automatic step(input bit rst_n, input bit se, input bit st, input bit re,
                        input bit rce, input int rid, input bit rct);
        i_reset = rst_n; i_spec_en = se; i_spec_taken = st; i_retire_en = re;
        i_recover_en = rce; i_recover_id = rid[PW-1:0]; i_recover_taken = rct;
        model_step(rst_n, se, st, re, rce, rid, rct);
        @(posedge clk);
        @(negedge clk);
        i_reset = 1'b1; i_spec_en = 1'b0; i_spec_taken = 1'b0; i_retire_en = 1'b0;
        i_recover_en = 1'b0; i_recover_id = '0; i_recover_taken = 1'b0;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3, 1'b1);
        vectors++;
        if ({o_hist, o_ckpt_cnt, o_ckpt_id} !== {14'h0, 4'd0, 3'd0}) begin
            $display("FAIL reset_state hist=%h cnt=%0d id=%0d exp 0/0/0", o_hist, o_ckpt_cnt, o_ckpt_id);
            miscompares++;
        end
        vectors++;
        if ({o_ckpt_full, o_ckpt_empty, o_recover_err} !== 3'b010) begin
            $display("FAIL reset_flags full/empty/err=%b exp 010", {o_ckpt_full, o_ckpt_empty, o_recover_err});
            miscompares++;
        end
`ifdef GHR_FOLD_EN
        vectors++;
        if (o_fold_hist !== '0) begin
            $display("FAIL reset_fold got=%h exp=0", o_fold_hist);
            miscompares++;
        end
`endif
    endtask

    task automatic test_shift();
        bit seq[9] = '{1, 0, 1, 0, 0, 1, 0, 1, 1};
        do_reset();
        foreach (seq[i]) step(1'b1, 1'b1, seq[i], 1'b1, 1'b0, 0, 1'b0);
        vectors++;
        if (o_hist !== 14'h014B) begin
            $display("FAIL shift_hist got=%h exp=014b", o_hist);
            miscompares++;
        end
        vectors++;
        if (o_ckpt_cnt !== 4'd1) begin
            $display("FAIL shift_cnt got=%0d exp=1", o_ckpt_cnt);
            miscompares++;
        end
`ifdef GHR_FOLD_EN
        vectors++;
        if (o_fold_hist !== 10'h14B) begin
            $display("FAIL shift_fold got=%h exp=14b", o_fold_hist);
            miscompares++;
        end
`endif
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < D; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        vectors++;
        if ({o_ckpt_full, o_ckpt_cnt, o_hist} !== {1'b1, 4'd8, 14'h00FF}) begin
            $display("FAIL full_state full=%b cnt=%0d hist=%h exp 1/8/00ff", o_ckpt_full, o_ckpt_cnt, o_hist);
            miscompares++;
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        vectors++;
        if ({o_hist, o_ckpt_id, o_ckpt_cnt} !== {14'h00FF, 3'd0, 4'd8}) begin
            $display("FAIL full_refuse hist=%h id=%0d cnt=%0d exp 00ff/0/8", o_hist, o_ckpt_id, o_ckpt_cnt);
            miscompares++;
        end
        // Spec + retire while full: spec still refused, retire frees one.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        vectors++;
        if ({o_hist, o_ckpt_cnt, o_ckpt_full} !== {14'h00FF, 4'd7, 1'b0}) begin
            $display("FAIL full_spec_retire hist=%h cnt=%0d full=%b exp 00ff/7/0", o_hist, o_ckpt_cnt, o_ckpt_full);
            miscompares++;
        end
    endtask

    task automatic test_recover();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        vectors++;
        if ({o_hist, o_ckpt_cnt, o_ckpt_id} !== {14'h0002, 4'd2, 3'd2}) begin
            $display("FAIL recover_basic hist=%h cnt=%0d id=%0d exp 0002/2/2", o_hist, o_ckpt_cnt, o_ckpt_id);
            miscompares++;
        end
    endtask

    task automatic test_wrap();
        logic [HW-1:0] h_before;
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, i[0], 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        vectors++;
        if ({o_ckpt_cnt, o_ckpt_id, o_hist} !== {4'd3, 3'd1, m_hist}) begin
            $display("FAIL wrap_recover cnt=%0d id=%0d hist=%h exp 3/1/%h", o_ckpt_cnt, o_ckpt_id, o_hist, m_hist);
            miscompares++;
        end
        h_before = m_hist;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0);
        vectors++;
        if ({o_recover_err, o_ckpt_cnt, o_ckpt_id, o_hist} !== {1'b1, 4'd3, 3'd1, h_before}) begin
            $display("FAIL wrap_err err=%b cnt=%0d id=%0d hist=%h exp 1/3/1/%h",
                     o_recover_err, o_ckpt_cnt, o_ckpt_id, o_hist, h_before);
            miscompares++;
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        vectors++;
        if (o_recover_err !== 1'b0) begin
            $display("FAIL wrap_err_pulse got=%b exp=0", o_recover_err);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        vectors++;
        if ({o_ckpt_empty, o_ckpt_cnt, o_ckpt_id, o_hist} !== {1'b1, 4'd0, 3'd1, 14'h0000}) begin
            $display("FAIL rec_retire empty=%b cnt=%0d id=%0d hist=%h exp 1/0/1/0000",
                     o_ckpt_empty, o_ckpt_cnt, o_ckpt_id, o_hist);
            miscompares++;
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b0);
        vectors++;
        if ({o_ckpt_cnt, o_ckpt_id, o_hist} !== {4'd1, 3'd2, 14'h0000}) begin
            $display("FAIL spec_drop cnt=%0d id=%0d hist=%h exp 1/2/0000", o_ckpt_cnt, o_ckpt_id, o_hist);
            miscompares++;
        end
    endtask

    task automatic test_midreset();
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        vectors++;
        if ({o_ckpt_cnt, o_hist} !== {4'd5, 14'h001F}) begin
            $display("FAIL midreset_pre cnt=%0d hist=%h exp 5/001f", o_ckpt_cnt, o_hist);
            miscompares++;
        end
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        vectors++;
        if ({o_hist, o_ckpt_cnt, o_ckpt_empty, o_ckpt_id} !== {14'h0, 4'd0, 1'b1, 3'd0}) begin
            $display("FAIL midreset hist=%h cnt=%0d empty=%b id=%0d exp 0/0/1/0",
                     o_hist, o_ckpt_cnt, o_ckpt_empty, o_ckpt_id);
            miscompares++;
        end
    endtask

    task automatic test_random();
        logic [HW-1:0] e_hist;
        logic [CW-1:0] e_cnt;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 6) == 0,
                 int'($urandom_range(0, D - 1)), 1'($urandom));
            e_hist = m_hist;
            e_cnt  = CW'(live_q.size());
            vectors++;
            if ({o_hist, o_ckpt_cnt, o_ckpt_full, o_ckpt_empty, o_recover_err, o_ckpt_id} !==
                {e_hist, e_cnt, live_q.size() == D, live_q.size() == 0, m_err, PW'(m_tail)}) begin
                $display("FAIL random[%0d] hist=%h cnt=%0d full=%b empty=%b err=%b id=%0d exp %h/%0d/%b/%b/%b/%0d",
                         n, o_hist, o_ckpt_cnt, o_ckpt_full, o_ckpt_empty, o_recover_err, o_ckpt_id,
                         e_hist, e_cnt, live_q.size() == D, live_q.size() == 0, m_err, m_tail);
                miscompares++;
            end
`ifdef GHR_FOLD_EN
            vectors++;
            if (o_fold_hist !== fold_of(e_hist)) begin
                $display("FAIL random_fold[%0d] got=%h exp=%h", n, o_fold_hist, fold_of(e_hist));
                miscompares++;
            end
`endif
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_shift();
        test_full();
        test_recover();
        test_wrap();
        test_back_to_back();
        test_midreset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
